alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 49 ++++
 rtl/alu_arbiter.sv | 99 +++++++++
 tb/tb_alu_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals around alu_arbiter.
// The arbiter uses the slave modport; the requesters/ALU/consumer side uses master.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_ctrl;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_ctrl;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_illegal;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  alu_result, alu_zero, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output alu_result, alu_zero, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation runs IDLE -> EXEC -> RESP; one operation is in flight at a time.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [3:0]       ctrl_q;
    logic             id_q, illegal_q, zero_q;

    logic             grant0, grant1, accept;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [3:0]       sel_ctrl;
    logic             sel_illegal;

    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // last_q = 1 means requester 1 won last, so requester 0 has priority
                if (bus.req0_valid && (!bus.req1_valid || last_q)) begin
                    grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_d = StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept      = grant0 | grant1;
    assign sel_a       = grant1 ? bus.req1_a : bus.req0_a;
    assign sel_b       = grant1 ? bus.req1_b : bus.req0_b;
    assign sel_ctrl    = grant1 ? bus.req1_ctrl : bus.req0_ctrl;
    assign sel_illegal = !(sel_ctrl inside {4'b0010, 4'b0110, 4'b0000, 4'b0001});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            id_q      <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q    <= grant1;
                a_q       <= sel_a;
                b_q       <= sel_b;
                ctrl_q    <= sel_ctrl;
                id_q      <= grant1;
                illegal_q <= sel_illegal;
            end
            if (state_q == StExec) begin
                result_q <= bus.alu_result;
                zero_q   <= bus.alu_zero;
            end
        end
    end

    // Reset gates the grant so nothing is offered while the async reset is held.
    assign bus.req0_ready  = grant0 & ~reset;
    assign bus.req1_ready  = grant1 & ~reset;

    assign bus.alu_a       = (state_q == StExec) ? a_q : '0;
    assign bus.alu_b       = (state_q == StExec) ? b_q : '0;
    assign bus.alu_ctrl    = (state_q == StExec) ? ctrl_q : 4'b0000;

    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.rsp_id      = id_q;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_zero    = zero_q;
    assign bus.rsp_illegal = illegal_q;
    assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; a behavioural ALU closes the loop.
// Inputs change on the falling edge, outputs are sampled there (or #1 later).
module tb_alu_arbiter;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] ctrl);
        case (ctrl)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_ctrl);
    assign bus.alu_zero   = (bus.alu_result == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_ctrl = 4'b0010; bus.req0_a = 32'd3;
        bus.req1_valid = 1'b1; bus.req1_ctrl = 4'b0001; bus.req1_b = 32'd4;
        @(negedge clk);
        tests++; if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL rst_ready0: got %0b want 0", bus.req0_ready); end
        tests++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL rst_ready1: got %0b want 0", bus.req1_ready); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %0b want 0", bus.rsp_valid); end
        tests++; if ({bus.rsp_id, bus.rsp_zero, bus.rsp_illegal} !== 3'b000) begin fails++; $display("FAIL rst_rsp_flags: got %0b want 000", {bus.rsp_id, bus.rsp_zero, bus.rsp_illegal}); end
        tests++; if (bus.rsp_result !== 32'd0) begin fails++; $display("FAIL rst_rsp_result: got %0h want 0", bus.rsp_result); end
        tests++; if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== 68'd0) begin fails++; $display("FAIL rst_alu: got %0h want 0", {bus.alu_a, bus.alu_b, bus.alu_ctrl}); end
        clear_reqs();
        reset = 1'b0;
    endtask

    task automatic test_single_add();
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_ctrl = 4'b0010; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
        #1;
        tests++; if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL add_ready0: got %0b want 1", bus.req0_ready); end
        tests++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL add_ready1: got %0b want 0", bus.req1_ready); end
        @(negedge clk);
        tests++; if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL add_exec_ready0: got %0b want 0", bus.req0_ready); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL add_exec_busy: got %0b want 1", bus.busy); end
        tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL add_exec_rsp_valid: got %0b want 0", bus.rsp_valid); end
        tests++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7 || bus.alu_ctrl !== 4'b0010) begin
            fails++; $display("FAIL add_exec_alu: got %0h/%0h/%0h want 5/7/2", bus.alu_a, bus.alu_b, bus.alu_ctrl);
        end
        clear_reqs();
        @(negedge clk);
        tests++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL add_rsp_valid: got %0b want 1", bus.rsp_valid); end
        tests++; if (bus.rsp_id !== 1'b0) begin fails++; $display("FAIL add_rsp_id: got %0b want 0", bus.rsp_id); end
        tests++; if (bus.rsp_result !== 32'd12) begin fails++; $display("FAIL add_rsp_result: got %0h want c", bus.rsp_result); end
        tests++; if (bus.rsp_zero !== 1'b0 || bus.rsp_illegal !== 1'b0) begin fails++; $display("FAIL add_rsp_flags: got z%0b i%0b want z0 i0", bus.rsp_zero, bus.rsp_illegal); end
        tests++; if (bus.alu_a !== 32'd0 || bus.alu_ctrl !== 4'd0) begin fails++; $display("FAIL add_resp_alu: got %0h/%0h want 0/0", bus.alu_a, bus.alu_ctrl); end
        @(negedge clk);
        tests++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL add_idle: got busy%0b valid%0b want 0 0", bus.busy, bus.rsp_valid); end
    endtask

    task automatic test_round_robin();
        reset = 1'b1; #2; reset = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_ctrl = 4'b0110; bus.req0_a = 32'd9;    bus.req0_b = 32'd9;
        bus.req1_valid = 1'b1; bus.req1_ctrl = 4'b0001; bus.req1_a = 32'hF0; bus.req1_b = 32'h0F;
        #1;
        tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin fails++; $display("FAIL rr_first_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin fails++; $display("FAIL rr_exec_ready: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        tests++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero} !== 3'b101) begin fails++; $display("FAIL rr_rsp0_flags: got %b want 101", {bus.rsp_valid, bus.rsp_id, bus.rsp_zero}); end
        tests++; if (bus.rsp_result !== 32'd0) begin fails++; $display("FAIL rr_rsp0_result: got %0h want 0", bus.rsp_result); end
        tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin fails++; $display("FAIL rr_resp_ready: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin fails++; $display("FAIL rr_second_grant: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        @(negedge clk);
        tests++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero} !== 3'b110) begin fails++; $display("FAIL rr_rsp1_flags: got %b want 110", {bus.rsp_valid, bus.rsp_id, bus.rsp_zero}); end
        tests++; if (bus.rsp_result !== 32'hFF) begin fails++; $display("FAIL rr_rsp1_result: got %0h want ff", bus.rsp_result); end
        @(negedge clk);
        tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin fails++; $display("FAIL rr_third_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        clear_reqs();
        @(negedge clk);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rr_drop_busy: got %0b want 0", bus.busy); end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_ctrl = 4'b0000; bus.req0_a = 32'hC; bus.req0_b = 32'hA;
        #1;
        tests++; if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL bp_grant: got %0b want 1", bus.req0_ready); end
        @(negedge clk);
        clear_reqs();
        bus.req1_valid = 1'b1; bus.req1_ctrl = 4'b0010; bus.req1_a = 32'd1; bus.req1_b = 32'd1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tests++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_illegal, bus.busy} !== 5'b10001) begin
                fails++; $display("FAIL bp_hold_flags[%0d]: got %b want 10001", i, {bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_illegal, bus.busy});
            end
            tests++; if (bus.rsp_result !== 32'h8) begin fails++; $display("FAIL bp_hold_result[%0d]: got %0h want 8", i, bus.rsp_result); end
            tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin fails++; $display("FAIL bp_hold_ready[%0d]: got %b want 00", i, {bus.req0_ready, bus.req1_ready}); end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        tests++; if ({bus.busy, bus.rsp_valid} !== 2'b00) begin fails++; $display("FAIL bp_release: got %b want 00", {bus.busy, bus.rsp_valid}); end
        tests++; if (bus.req1_ready !== 1'b1) begin fails++; $display("FAIL bp_next_grant: got %0b want 1", bus.req1_ready); end
        clear_reqs();
        @(negedge clk);
    endtask

    task automatic test_illegal();
        bus.rsp_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_ctrl = 4'b0111; bus.req1_a = 32'h1234; bus.req1_b = 32'h5678;
        #1;
        tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin fails++; $display("FAIL ill_grant: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        clear_reqs();
        tests++; if (bus.alu_ctrl !== 4'b0111) begin fails++; $display("FAIL ill_alu_ctrl: got %0h want 7", bus.alu_ctrl); end
        @(negedge clk);
        tests++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_illegal} !== 4'b1111) begin
            fails++; $display("FAIL ill_rsp_flags: got %b want 1111", {bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_illegal});
        end
        tests++; if (bus.rsp_result !== 32'd0) begin fails++; $display("FAIL ill_rsp_result: got %0h want 0", bus.rsp_result); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_ctrl = 4'b0010; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
        #1;
        tests++; if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL rx_grant: got %0b want 1", bus.req0_ready); end
        @(negedge clk);
        clear_reqs();
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rx_exec_busy: got %0b want 1", bus.busy); end
        #2 reset = 1'b1;
        #1;
        tests++; if ({bus.busy, bus.rsp_valid} !== 2'b00) begin fails++; $display("FAIL rx_async_clear: got %b want 00", {bus.busy, bus.rsp_valid}); end
        tests++; if (bus.alu_a !== 32'd0 || bus.alu_ctrl !== 4'd0) begin fails++; $display("FAIL rx_async_alu: got %0h/%0h want 0/0", bus.alu_a, bus.alu_ctrl); end
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if ({bus.busy, bus.rsp_valid} !== 2'b00) begin fails++; $display("FAIL rx_no_rsp: got %b want 00", {bus.busy, bus.rsp_valid}); end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin fails++; $display("FAIL rx_contention: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        clear_reqs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic exp_ready;
        logic exp_valid;
        bus.rsp_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_ctrl = 4'b0010; bus.req1_a = 32'd1; bus.req1_b = 32'd2;
        for (int k = 0; k < 9; k++) begin
            #1;
            exp_ready = (k % 3 == 0);
            exp_valid = (k % 3 == 2);
            tests++; if (bus.req1_ready !== exp_ready || bus.req0_ready !== 1'b0) begin
                fails++; $display("FAIL b2b_ready[%0d]: got %b want 0%b", k, {bus.req0_ready, bus.req1_ready}, exp_ready);
            end
            tests++; if (bus.rsp_valid !== exp_valid) begin fails++; $display("FAIL b2b_valid[%0d]: got %0b want %0b", k, bus.rsp_valid, exp_valid); end
            if (exp_valid) begin
                tests++; if (bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'd3 || bus.rsp_illegal !== 1'b0) begin
                    fails++; $display("FAIL b2b_rsp[%0d]: got id%0b res%0h ill%0b want id1 res3 ill0", k, bus.rsp_id, bus.rsp_result, bus.rsp_illegal);
                end
            end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.rsp_ready = 1'b0;
        clear_reqs();
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_reset_mid_exec();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
